// File: rtl/pipe_decode_pkg.sv
// Shared RiSC16 widths, opcodes and the ID/EX bundle.
// Used by the decode and execute stages.
package pipe_decode_pkg;

    localparam int WORD_LEN     = 16;
    localparam int REG_ADDR_LEN = 3;

    typedef logic [WORD_LEN-1:0]     word_t;
    typedef logic [REG_ADDR_LEN-1:0] reg_t;
    typedef logic [2:0]              op_t;

    localparam op_t OP_ADD  = 3'b000;
    localparam op_t OP_ADDI = 3'b001;
    localparam op_t OP_NAND = 3'b010;
    localparam op_t OP_LUI  = 3'b011;
    localparam op_t OP_SW   = 3'b100;
    localparam op_t OP_LW   = 3'b101;
    localparam op_t OP_BEQ  = 3'b110;
    localparam op_t OP_JALR = 3'b111;

    typedef struct packed {
        logic  valid;
        op_t   op;
        reg_t  tgt;
        word_t a;
        word_t b;
        word_t imm;
        word_t pc;
    } id_ex_t;

    function automatic word_t decode_imm(input word_t instr);
        word_t imm;
        case (instr[15:13])
            OP_ADDI, OP_SW, OP_LW, OP_BEQ:
                imm = {{9{instr[6]}}, instr[6:0]};
            OP_LUI:
                imm = {instr[9:0], 6'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/pipe_decode_hazard.sv
// Load-use and write-back hazard detection for the decode stage.
// PIPE_DECODE_FORWARD_EN selects write-back bypass over a stall.
module id_hazard
    import pipe_decode_pkg::*;
(
    input  op_t  op,
    input  reg_t src1,
    input  reg_t src2,
    input  logic if_valid,
    input  logic ex_valid,
    input  op_t  ex_op,
    input  reg_t ex_tgt,
    input  logic wb_writeEn,
    input  reg_t wb_tgt,
    output logic hz,
    output logic wbhz,
    output logic byp1,
    output logic byp2
);

    logic uses1;
    logic uses2;
    logic wb_m1;
    logic wb_m2;

    always_comb begin
        uses1 = (op != OP_LUI);
        uses2 = (op inside {OP_ADD, OP_NAND, OP_SW, OP_BEQ});

        hz = if_valid && ex_valid &&
             (ex_op == OP_LW) && (ex_tgt != '0) &&
             ((uses1 && (src1 == ex_tgt)) ||
              (uses2 && (src2 == ex_tgt)));

        wb_m1 = wb_writeEn && (wb_tgt != '0) &&
                uses1 && (src1 == wb_tgt);
        wb_m2 = wb_writeEn && (wb_tgt != '0) &&
                uses2 && (src2 == wb_tgt);

`ifdef PIPE_DECODE_FORWARD_EN
        byp1 = wb_m1;
        byp2 = wb_m2;
        wbhz = 1'b0;
`else
        // Stall one cycle so the RF write lands before capture.
        byp1 = 1'b0;
        byp2 = 1'b0;
        wbhz = if_valid && (wb_m1 || wb_m2);
`endif
    end

endmodule

// File: rtl/pipe_decode.sv
// RiSC16 decode stage: RF addressing, immediates, ID/EX register.
// Optional write-back bypass via PIPE_DECODE_FORWARD_EN.
module pipe_decode
    import pipe_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    output logic [2:0]  rf_src1,
    output logic [2:0]  rf_src2,
    input  logic [15:0] rf_out1,
    input  logic [15:0] rf_out2,
    input  logic        wb_writeEn,
    input  logic [2:0]  wb_tgt,
    input  logic [15:0] wb_data,
    input  logic        ex_stall,
    input  logic        ex_flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [2:0]  ex_op,
    output logic [2:0]  ex_tgt,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_pc
);

    op_t    op;
    logic   hz;
    logic   wbhz;
    logic   byp1;
    logic   byp2;
    id_ex_t d;
    id_ex_t q;

    assign op      = if_instr[15:13];
    assign rf_src1 = if_instr[9:7];
    assign rf_src2 = (op == OP_ADD || op == OP_NAND) ?
                     if_instr[2:0] : if_instr[12:10];

    id_hazard u_hazard (
        .op         (op),
        .src1       (rf_src1),
        .src2       (rf_src2),
        .if_valid   (if_valid),
        .ex_valid   (q.valid),
        .ex_op      (q.op),
        .ex_tgt     (q.tgt),
        .wb_writeEn (wb_writeEn),
        .wb_tgt     (wb_tgt),
        .hz         (hz),
        .wbhz       (wbhz),
        .byp1       (byp1),
        .byp2       (byp2)
    );

    always_comb begin
        d.valid = if_valid;
        d.op    = op;
        d.tgt   = if_instr[12:10];
        d.a     = byp1 ? wb_data : rf_out1;
        d.b     = byp2 ? wb_data : rf_out2;
        d.imm   = decode_imm(if_instr);
        d.pc    = if_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ex_stall) begin
            q <= q;
        end else if (ex_flush || hz || wbhz) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    // Hazards cannot stall fetch while reset holds ID/EX empty.
    assign id_stall = ex_stall ||
                      (rst && (hz || wbhz) && !ex_flush);

    assign ex_valid = q.valid;
    assign ex_op    = q.op;
    assign ex_tgt   = q.tgt;
    assign ex_a     = q.a;
    assign ex_b     = q.b;
    assign ex_imm   = q.imm;
    assign ex_pc    = q.pc;

endmodule

// File: tb/tb_pipe_decode.sv
// Self-checking bench for pipe_decode: vector table plus
// hazard, bypass, flush, stall and reset sequences.
module tb_pipe_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [15:0] if_pc = '0;
    logic [2:0]  rf_src1;
    logic [2:0]  rf_src2;
    logic [15:0] rf_out1 = '0;
    logic [15:0] rf_out2 = '0;
    logic        wb_writeEn = 1'b0;
    logic [2:0]  wb_tgt = '0;
    logic [15:0] wb_data = '0;
    logic        ex_stall = 1'b0;
    logic        ex_flush = 1'b0;
    logic        id_stall;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [2:0]  ex_tgt;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc;

    pipe_decode dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rf_src1    (rf_src1),
        .rf_src2    (rf_src2),
        .rf_out1    (rf_out1),
        .rf_out2    (rf_out2),
        .wb_writeEn (wb_writeEn),
        .wb_tgt     (wb_tgt),
        .wb_data    (wb_data),
        .ex_stall   (ex_stall),
        .ex_flush   (ex_flush),
        .id_stall   (id_stall),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_tgt     (ex_tgt),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_imm     (ex_imm),
        .ex_pc      (ex_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [2:0]  tgt;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        v;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  op;
        logic [2:0]  tgt;
        logic [15:0] imm;
    } vec_t;

    exp_t sb[$];
    vec_t vt[10];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic [2:0] op,
                        input logic [2:0] tgt,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm,
                        input logic [15:0] pc);
        exp_t e;
        e.v = v; e.op = op; e.tgt = tgt;
        e.a = a; e.b = b; e.imm = imm; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic bubble();
        push(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic tick(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".valid"}, 16'(ex_valid), 16'(e.v));
            chk({nm, ".op"}, 16'(ex_op), 16'(e.op));
            chk({nm, ".tgt"}, 16'(ex_tgt), 16'(e.tgt));
            chk({nm, ".a"}, ex_a, e.a);
            chk({nm, ".b"}, ex_b, e.b);
            chk({nm, ".imm"}, ex_imm, e.imm);
            chk({nm, ".pc"}, ex_pc, e.pc);
        end
    endtask

    task automatic drive(input logic [15:0] ins,
                         input logic [15:0] pc,
                         input logic v,
                         input logic [15:0] r1,
                         input logic [15:0] r2);
        if_instr = ins;
        if_pc    = pc;
        if_valid = v;
        rf_out1  = r1;
        rf_out2  = r2;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".valid"}, 16'(ex_valid), 16'h0);
        chk({nm, ".op"}, 16'(ex_op), 16'h0);
        chk({nm, ".tgt"}, 16'(ex_tgt), 16'h0);
        chk({nm, ".a"}, ex_a, 16'h0);
        chk({nm, ".b"}, ex_b, 16'h0);
        chk({nm, ".imm"}, ex_imm, 16'h0);
        chk({nm, ".pc"}, ex_pc, 16'h0);
    endtask

    initial begin
        vt[0] = '{16'h28FF, 1, 16'h0007, 16'h0055,
                  1, 2, 1, 2, 16'hFFFF};
        vt[1] = '{16'h6FFF, 1, 16'hAAAA, 16'h5555,
                  7, 3, 3, 3, 16'hFFC0};
        vt[2] = '{16'h0503, 1, 16'h1111, 16'h2222,
                  2, 3, 0, 1, 16'h0000};
        vt[3] = '{16'h5F05, 1, 16'h3333, 16'h4444,
                  6, 5, 2, 7, 16'h0000};
        vt[4] = '{16'h92C0, 1, 16'h0BAD, 16'hF00D,
                  5, 4, 4, 4, 16'hFFC0};
        vt[5] = '{16'hC503, 1, 16'h1234, 16'h1234,
                  2, 1, 6, 1, 16'h0003};
        vt[6] = '{16'hF980, 1, 16'h0300, 16'h0000,
                  3, 6, 7, 6, 16'h0000};
        vt[7] = '{16'hA0BF, 1, 16'h8000, 16'h7FFF,
                  1, 0, 5, 0, 16'h003F};
        vt[8] = '{16'h0800, 0, 16'h0000, 16'h0000,
                  0, 0, 0, 2, 16'h0000};
        vt[9] = '{16'h2481, 1, 16'hFFFF, 16'h0001,
                  1, 1, 1, 1, 16'h0001};

        // Reset behaviour
        drive(16'h28FF, 16'h0010, 1'b1, 16'h7, 16'h0);
        wb_writeEn = 1'b1;
        wb_tgt     = 3'd1;
        wb_data    = 16'hBEEF;
        ex_stall   = 1'b1;
        #2;
        chk("rst.src1", 16'(rf_src1), 16'd1);
        chk("rst.src2", 16'(rf_src2), 16'd2);
        chk("rst.stall_hi", 16'(id_stall), 16'd1);
        ex_stall = 1'b0;
        #1;
        chk("rst.stall_lo", 16'(id_stall), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("rst.hold");
        rst        = 1'b1;
        wb_writeEn = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].instr, 16'h0100 + 16'(i),
                  vt[i].v, vt[i].r1, vt[i].r2);
            #1;
            chk($sformatf("vec%0d.src1", i),
                16'(rf_src1), 16'(vt[i].s1));
            chk($sformatf("vec%0d.src2", i),
                16'(rf_src2), 16'(vt[i].s2));
            chk($sformatf("vec%0d.stall", i),
                16'(id_stall), 16'd0);
            push(vt[i].v, vt[i].op, vt[i].tgt,
                 vt[i].r1, vt[i].r2, vt[i].imm,
                 16'h0100 + 16'(i));
            tick($sformatf("vec%0d", i));
        end

        // Load-use: LW r1 then ADD r4,r1,r0
        drive(16'hA505, 16'h0040, 1'b1, 16'h0010, 16'h0020);
        push(1, 3'd5, 3'd1, 16'h0010, 16'h0020,
             16'h0005, 16'h0040);
        tick("lu.lw");
        drive(16'h1080, 16'h0041, 1'b1, 16'h0003, 16'h0000);
        #1;
        chk("lu.stall", 16'(id_stall), 16'd1);
        bubble();
        tick("lu.bubble");
        chk("lu.release", 16'(id_stall), 16'd0);
        push(1, 3'd0, 3'd4, 16'h0003, 16'h0000,
             16'h0000, 16'h0041);
        tick("lu.add");

        // LUI after LW r3: no source used, no stall
        drive(16'hAC01, 16'h0050, 1'b1, 16'h0000, 16'h0000);
        push(1, 3'd5, 3'd3, 16'h0, 16'h0, 16'h0001, 16'h0050);
        tick("lui.lw");
        drive(16'h6FFF, 16'h0051, 1'b1, 16'hAAAA, 16'h5555);
        #1;
        chk("lui.stall", 16'(id_stall), 16'd0);
        push(1, 3'd3, 3'd3, 16'hAAAA, 16'h5555,
             16'hFFC0, 16'h0051);
        tick("lui.issue");

        // Write-back to a source being decoded
        drive(16'h0503, 16'h0060, 1'b1, 16'h0000, 16'h0777);
        wb_writeEn = 1'b1;
        wb_tgt     = 3'd2;
        wb_data    = 16'h1234;
        #1;
`ifdef PIPE_DECODE_FORWARD_EN
        chk("wb.stall", 16'(id_stall), 16'd0);
        push(1, 3'd0, 3'd1, 16'h1234, 16'h0777,
             16'h0000, 16'h0060);
        tick("wb.byp");
        wb_writeEn = 1'b0;
`else
        chk("wb.stall", 16'(id_stall), 16'd1);
        bubble();
        tick("wb.bubble");
        wb_writeEn = 1'b0;
        rf_out1    = 16'h1234;
        #1;
        chk("wb.release", 16'(id_stall), 16'd0);
        push(1, 3'd0, 3'd1, 16'h1234, 16'h0777,
             16'h0000, 16'h0060);
        tick("wb.issue");
`endif

        // Flush beats a pending load-use hazard
        drive(16'hA505, 16'h0070, 1'b1, 16'h0010, 16'h0020);
        push(1, 3'd5, 3'd1, 16'h0010, 16'h0020,
             16'h0005, 16'h0070);
        tick("fl.lw");
        drive(16'h1080, 16'h0071, 1'b1, 16'h0003, 16'h0000);
        ex_flush = 1'b1;
        #1;
        chk("fl.stall", 16'(id_stall), 16'd0);
        bubble();
        tick("fl.bubble");
        ex_flush = 1'b0;

        // Stall with flush holds ID/EX
        drive(16'h28FF, 16'h0080, 1'b1, 16'h0007, 16'h0001);
        push(1, 3'd1, 3'd2, 16'h0007, 16'h0001,
             16'hFFFF, 16'h0080);
        tick("st.addi");
        drive(16'h5F05, 16'h0081, 1'b1, 16'h9999, 16'h8888);
        ex_stall = 1'b1;
        ex_flush = 1'b1;
        #1;
        chk("st.stall", 16'(id_stall), 16'd1);
        push(1, 3'd1, 3'd2, 16'h0007, 16'h0001,
             16'hFFFF, 16'h0080);
        tick("st.hold");
        ex_stall = 1'b0;
        ex_flush = 1'b0;

        // Reset asserted in the middle of a load-use stall
        drive(16'hA505, 16'h0090, 1'b1, 16'h0010, 16'h0020);
        push(1, 3'd5, 3'd1, 16'h0010, 16'h0020,
             16'h0005, 16'h0090);
        tick("rm.lw");
        drive(16'h1080, 16'h0091, 1'b1, 16'h0005, 16'h0000);
        #1;
        chk("rm.stall", 16'(id_stall), 16'd1);
        rst = 1'b0;
        #1;
        chk_zero("rm.clear");
        chk("rm.nostall", 16'(id_stall), 16'd0);
        #2;
        rst = 1'b1;
        push(1, 3'd0, 3'd4, 16'h0005, 16'h0000,
             16'h0000, 16'h0091);
        tick("rm.add");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
